// File: rtl/alu.sv
// alu: MIPS execute-stage ALU with registered result, next PC and branch-taken flag.
// Define ALU_OVERFLOW_EN to add the registered signed-overflow output alu_overflow.
module alu #(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic                 a_i_clk,
    input  logic                 a_i_rst,
    input  logic                 a_i_stall,
    input  logic [DWIDTH-1:0]    a_i_data_rs,
    input  logic [DWIDTH-1:0]    a_i_data_rt,
    input  logic [IMM_WIDTH-1:0] a_i_imm,
    input  logic [4:0]           a_i_funct,
    input  logic                 a_i_alu_src,
    input  logic [PC_WIDTH-1:0]  a_i_pc,
`ifdef ALU_OVERFLOW_EN
    output logic                 alu_overflow,
`endif
    output logic [DWIDTH-1:0]    alu_value,
    output logic [PC_WIDTH-1:0]  alu_pc,
    output logic                 alu_taken
);
    logic                zext, taken;
    logic [DWIDTH-1:0]   ext_imm, b, sum, diff, br_diff, value;
    logic [4:0]          shamt;
    logic [PC_WIDTH-1:0] pc_inc, br_off, pc_next;
    assign zext    = a_i_funct inside {5'd2, 5'd3, 5'd4};
    assign ext_imm = {{(DWIDTH-IMM_WIDTH){zext ? 1'b0 : a_i_imm[IMM_WIDTH-1]}}, a_i_imm};
    assign b       = a_i_alu_src ? ext_imm : a_i_data_rt;
    assign shamt   = b[4:0];
    assign sum     = a_i_data_rs + b;
    assign diff    = a_i_data_rs - b;
    // Branches always compare rs against rt, never against the immediate.
    assign br_diff = a_i_data_rs - a_i_data_rt;
    always_comb begin
        value = '0;
        case (a_i_funct)
            5'd0:  value = sum;
            5'd1:  value = diff;
            5'd2:  value = a_i_data_rs & b;
            5'd3:  value = a_i_data_rs | b;
            5'd4:  value = a_i_data_rs ^ b;
            5'd5:  value = ~(a_i_data_rs | b);
            5'd6:  value = {{(DWIDTH-1){1'b0}}, $signed(a_i_data_rs) < $signed(b)};
            5'd7:  value = {{(DWIDTH-1){1'b0}}, a_i_data_rs < b};
            5'd8:  value = a_i_data_rs << shamt;
            5'd9:  value = a_i_data_rs >> shamt;
            5'd10: value = $signed(a_i_data_rs) >>> shamt;
            5'd11: value = ext_imm << 16;
            5'd12, 5'd13, 5'd14, 5'd15: value = br_diff;
            default: value = '0;
        endcase
    end
    assign taken = (a_i_funct == 5'd12 && a_i_data_rs != a_i_data_rt) ||
                   (a_i_funct == 5'd13 &&  a_i_data_rs[DWIDTH-1]) ||
                   (a_i_funct == 5'd14 && !a_i_data_rs[DWIDTH-1]) ||
                   (a_i_funct == 5'd15 && a_i_data_rs == a_i_data_rt);
    assign pc_inc  = a_i_pc + PC_WIDTH'(4);
    assign br_off  = {{(PC_WIDTH-IMM_WIDTH-2){a_i_imm[IMM_WIDTH-1]}}, a_i_imm, 2'b00};
    assign pc_next = pc_inc + (taken ? br_off : '0);
`ifdef ALU_OVERFLOW_EN
    logic ovf;
    assign ovf = (a_i_funct == 5'd0 && a_i_data_rs[DWIDTH-1] == b[DWIDTH-1] && sum[DWIDTH-1] != a_i_data_rs[DWIDTH-1]) ||
                 (a_i_funct == 5'd1 && a_i_data_rs[DWIDTH-1] != b[DWIDTH-1] && diff[DWIDTH-1] != a_i_data_rs[DWIDTH-1]);
    always_ff @(posedge a_i_clk or negedge a_i_rst) begin
        if (!a_i_rst) alu_overflow <= 1'b0;
        else if (!a_i_stall) alu_overflow <= ovf;
    end
`endif
    always_ff @(posedge a_i_clk or negedge a_i_rst) begin
        if (!a_i_rst) begin
            alu_value <= '0;
            alu_pc    <= '0;
            alu_taken <= 1'b0;
        end else if (!a_i_stall) begin
            alu_value <= value;
            alu_pc    <= pc_next;
            alu_taken <= taken;
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and random scoreboard bench for alu.
module tb_alu;
    typedef struct {
        logic [31:0] v;
        logic [31:0] pc;
        logic        t;
        logic        o;
        string       tag;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, src = 1'b0;
    logic [31:0] rs = '0, rt = '0, pc = '0, value, npc;
    logic [15:0] imm = '0;
    logic [4:0]  funct = '0;
    logic        taken, ovf;
    int          passed = 0, total = 0;
    exp_t        q[$];
    exp_t        last;
    always #5 clk = ~clk;
    alu dut (
        .a_i_clk(clk), .a_i_rst(rst), .a_i_stall(stall),
        .a_i_data_rs(rs), .a_i_data_rt(rt), .a_i_imm(imm), .a_i_funct(funct),
        .a_i_alu_src(src), .a_i_pc(pc),
`ifdef ALU_OVERFLOW_EN
        .alu_overflow(ovf),
`endif
        .alu_value(value), .alu_pc(npc), .alu_taken(taken)
    );
`ifndef ALU_OVERFLOW_EN
    assign ovf = 1'b0;
`endif
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] r, input logic [15:0] i,
                                   input logic s, input logic [4:0] f, input logic [31:0] p);
        exp_t e;
        logic [31:0] sx, bb;
        longint w;
        sx = {{16{i[15]}}, i};
        bb = s ? ((f >= 5'd2 && f <= 5'd4) ? {16'h0, i} : sx) : r;
        e.t = 1'b0;
        e.o = 1'b0;
        e.v = 32'h0;
        case (f)
            5'd0: begin e.v = a + bb; w = longint'($signed(a)) + longint'($signed(bb)); e.o = w > 64'sd2147483647 || w < -64'sd2147483648; end
            5'd1: begin e.v = a - bb; w = longint'($signed(a)) - longint'($signed(bb)); e.o = w > 64'sd2147483647 || w < -64'sd2147483648; end
            5'd2: e.v = a & bb;
            5'd3: e.v = a | bb;
            5'd4: e.v = a ^ bb;
            5'd5: e.v = ~a & ~bb;
            5'd6: e.v = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            5'd7: e.v = (a < bb) ? 32'd1 : 32'd0;
            5'd8: e.v = a << bb[4:0];
            5'd9: e.v = a >> bb[4:0];
            5'd10: e.v = $signed(a) >>> bb[4:0];
            5'd11: e.v = {i, 16'h0};
            5'd12: begin e.v = a - r; e.t = a != r; end
            5'd13: begin e.v = a - r; e.t = $signed(a) < 0; end
            5'd14: begin e.v = a - r; e.t = $signed(a) >= 0; end
            5'd15: begin e.v = a - r; e.t = a == r; end
            default: e.v = 32'h0;
        endcase
        e.pc = p + 32'd4 + (e.t ? (sx << 2) : 32'd0);
        return e;
    endfunction
    task automatic check_out();
        exp_t e;
        e = q.pop_front();
        chk({e.tag, ".value"}, value, e.v);
        chk({e.tag, ".pc"}, npc, e.pc);
        chk({e.tag, ".taken"}, {31'b0, taken}, {31'b0, e.t});
`ifdef ALU_OVERFLOW_EN
        chk({e.tag, ".ovf"}, {31'b0, ovf}, {31'b0, e.o});
`endif
        last = e;
    endtask
    task automatic step(input logic [31:0] a, input logic [31:0] r, input logic [15:0] i, input logic s,
                        input logic [4:0] f, input logic [31:0] p, input logic [31:0] ev,
                        input logic [31:0] epc, input logic et, input logic eo, input string tag);
        exp_t e;
        rs = a; rt = r; imm = i; src = s; funct = f; pc = p;
        e.v = ev; e.pc = epc; e.t = et; e.o = eo; e.tag = tag;
        q.push_back(e);
        @(posedge clk); #1;
        check_out();
    endtask
    task automatic mstep(input logic [31:0] a, input logic [31:0] r, input logic [15:0] i, input logic s,
                         input logic [4:0] f, input logic [31:0] p, input string tag);
        exp_t e;
        e = model(a, r, i, s, f, p);
        step(a, r, i, s, f, p, e.v, e.pc, e.t, e.o, tag);
    endtask
    initial begin
        @(posedge clk); @(posedge clk); #1;
        chk("reset.value", value, 32'h0);
        chk("reset.pc", npc, 32'h0);
        chk("reset.taken", {31'b0, taken}, 32'h0);
        rst = 1'b1;
        step(5, 4, 4, 0, 0, 10, 9, 14, 0, 0, "add_reg");
        step(5, 4, 10, 1, 0, 10, 15, 14, 0, 0, "add_imm");
        step(5, 4, 16'hFFFF, 1, 0, 10, 4, 14, 0, 0, "add_imm_neg");
        step(5, 5, 4, 0, 15, 10, 0, 30, 1, 0, "beq_taken");
        step(5, 4, 4, 0, 15, 10, 1, 14, 0, 0, "beq_not");
        step(5, 5, 1, 1, 15, 10, 0, 18, 1, 0, "beq_src_imm");
        step(0, 0, 16'h8000, 1, 3, 10, 32'h00008000, 14, 0, 0, "ori");
        step(32'h80000000, 4, 0, 0, 10, 10, 32'hF8000000, 14, 0, 0, "sra");
        step(32'hFFFFFFFF, 1, 0, 0, 6, 10, 1, 14, 0, 0, "slt");
        step(32'hFFFFFFFF, 1, 0, 0, 7, 10, 0, 14, 0, 0, "sltu");
        step(0, 0, 16'h1234, 1, 11, 10, 32'h12340000, 14, 0, 0, "lui");
        step(1, 2, 16'hFFFF, 0, 12, 100, 32'hFFFFFFFF, 100, 1, 0, "bne_back");
        step(32'h80000000, 0, 2, 0, 13, 0, 32'h80000000, 12, 1, 0, "bltz");
        step(32'h80000000, 0, 2, 0, 14, 0, 32'h80000000, 4, 0, 0, "bgez_not");
        step(32'hFFFFFFFF, 32'h5, 16'h7, 1, 20, 32'hFFFFFFFC, 0, 0, 0, 0, "reserved_wrap");
        step(32'h7FFFFFFF, 1, 0, 0, 0, 8, 32'h80000000, 12, 0, 1, "add_ovf");
        step(32'h80000000, 1, 0, 0, 1, 8, 32'h7FFFFFFF, 12, 0, 1, "sub_ovf");
        stall = 1'b1;
        rs = 32'h11; rt = 32'h22; imm = 16'h3; funct = 5'd15; pc = 32'h400;
        q.push_back(last);
        q[$].tag = "stall";
        @(posedge clk); @(posedge clk); #1;
        check_out();
        stall = 1'b0;
        for (int k = 0; k < 40; k++)
            mstep($urandom, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 16'($urandom),
                  1'($urandom), 5'($urandom_range(0, 17)), $urandom, $sformatf("rand%0d", k));
        step(32'h100, 32'h1, 0, 0, 0, 16, 32'h101, 20, 0, 0, "pre_reset");
        #3 rst = 1'b0;
        #1;
        chk("async_reset.value", value, 32'h0);
        chk("async_reset.pc", npc, 32'h0);
        chk("async_reset.taken", {31'b0, taken}, 32'h0);
        @(posedge clk); #1;
        chk("reset_hold.value", value, 32'h0);
        rst = 1'b1;
        mstep(32'h12345678, 32'h9, 0, 0, 8, 32'h20, "after_reset_sll");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
